ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Hazard and sequencing controller for the execute stage of the 5-stage MIPS pipeline.
- Generates forwarding selects for both ALU source operands.
- Detects load-use hazards and issues stall/flush.
- Sequences multi-cycle execute operations (multiply/divide class) by holding EX for a fixed latency while upstream stalls and MEM receives bubbles.

Parameters:
MC_LATENCY, 4, total EX-stage cycles of a multi-cycle op; legal range 2..16
CNT_W, 4, width of the internal latency counter; must hold MC_LATENCY-2

Ports:
CLK  input  1  pipeline clock, rising edge
RSTn  input  1  asynchronous active-low reset
RsAddrD  input  5  Rs field of instruction in decode
RtAddrD  input  5  Rt field of instruction in decode
UseRtD  input  1  decode instruction reads Rt
RsAddrE  input  5  Rs of instruction in execute
RtAddrE  input  5  Rt of instruction in execute
WriteRegE  input  5  destination of instruction in execute
RegWriteE  input  1  execute instruction writes register file
MemToRegE  input  1  execute instruction is a load
MultiCycleE  input  1  execute instruction is a multi-cycle op
FlushReqE  input  1  branch/exception kill of the execute instruction
WriteRegM  input  5  destination in memory stage
RegWriteM  input  1  memory stage writes register file
WriteRegW  input  5  destination in writeback stage
RegWriteW  input  1  writeback stage writes register file
ForwardAE  output  2  RegSrcA select: 00 regfile, 10 MEM ALUResult, 01 WB result
ForwardBE  output  2  RegSrcB select, same encoding
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register and EX inputs
FlushE  output  1  clear ID/EX register (insert bubble into EX)
BubbleM  output  1  EX/MEM register loads a bubble (RegWrite/MemWrite = 0)
McDoneE  output  1  one-cycle pulse: multi-cycle result valid this cycle
BusyE  output  1  state == BUSY

Behaviour:
- Reset (RSTn low, asynchronous): state = IDLE, counter = 0.
  - Stall/flush/bubble/done/busy outputs all 0 while in reset.
  - Forwarding outputs remain combinational.
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM & WriteRegM != 0 & WriteRegM == RsAddrE.
  - Else 01 if RegWriteW & WriteRegW != 0 & WriteRegW == RsAddrE.
  - Else 00.
  - MEM has priority over WB. ForwardBE is identical using RtAddrE.
- Load-use (combinational):
  - lu = MemToRegE & RegWriteE & WriteRegE != 0 & (WriteRegE == RsAddrD | (UseRtD & WriteRegE == RtAddrD)).
  - lu asserts StallF, StallD, FlushE. No latency cost beyond one bubble.
- FSM states: IDLE, BUSY.
  - start = IDLE & MultiCycleE & !FlushReqE.
  - IDLE -> BUSY on start. Counter loads MC_LATENCY-2.
  - BUSY with counter != 0: counter decrements, stays BUSY.
  - BUSY with counter == 0: McDoneE = 1, stalls released, next state IDLE.
  - BUSY with FlushReqE: abort immediately. Next state IDLE, McDoneE = 0, stalls released in that cycle.
- Multi-cycle stall:
  - mcs = start | (BUSY & counter != 0 & !FlushReqE).
  - mcs asserts StallF, StallD, StallE, BubbleM.
  - Op occupies EX exactly MC_LATENCY cycles: MC_LATENCY-1 stall cycles plus the McDoneE cycle.
- Priority:
  - When mcs is asserted, FlushE = 0 even if lu is true. The decode instruction is held, and lu is re-evaluated after release.
  - FlushReqE is ORed into FlushE by the pipeline elsewhere; this block only uses it for abort/start suppression.
- MultiCycleE in IDLE on the cycle after McDoneE starts a new op (back-to-back legal).
- RSTn asserted mid-BUSY: immediate return to IDLE. No McDoneE pulse.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds output ports:
  - StallCycles[31:0]: increments each cycle StallF = 1.
  - McOps[15:0]: increments on each McDoneE.
  - Both reset to 0 asynchronously and saturate at all-ones.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- RegWriteM=1, WriteRegM=5, RegWriteW=1, WriteRegW=5, RsAddrE=5 -> ForwardAE=10. Same with WriteRegM=0 and RsAddrE=0 -> ForwardAE=00.
- MemToRegE=RegWriteE=1, WriteRegE=8, RtAddrD=8, UseRtD=1 -> StallF=StallD=FlushE=1 for one cycle. With UseRtD=0 -> all 0.
- MC_LATENCY=4, MultiCycleE held from cycle t:
  - StallE=1 at t, t+1, t+2.
  - McDoneE=1, StallE=0 at t+3.
  - BusyE=1 at t+1..t+3.
  - BubbleM=1 at t..t+2.
- Multi-cycle op started, FlushReqE=1 at t+1 -> stalls 0 at t+1, McDoneE never pulses, BusyE=0 at t+2.
- Load-use condition true during a BUSY cycle -> FlushE=0, StallE=1. After McDoneE, lu still true -> FlushE=1 on the next cycle.
- RSTn pulsed low at t+1 of a multi-cycle op -> BusyE and all stalls 0 asynchronously. With MultiCycleE low after reset release, no McDoneE.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: hazard and sequencing controller for the execute stage of
// a 5-stage MIPS pipeline.
//   - Forwarding selects for both ALU operands (MEM has priority over WB).
//   - Load-use detection: stalls IF/ID and flushes ID/EX for one bubble.
//   - Multi-cycle EX sequencing: holds EX for MC_LATENCY cycles while the
//     front end stalls and MEM receives bubbles; FlushReqE aborts the op.
// Ports:
//   CLK, RSTn                      clock, async active-low reset
//   RsAddrD/RtAddrD/UseRtD         decode-stage source operands
//   RsAddrE/RtAddrE/WriteRegE,
//   RegWriteE/MemToRegE,
//   MultiCycleE/FlushReqE          execute-stage instruction info
//   WriteRegM/RegWriteM,
//   WriteRegW/RegWriteW            downstream writers
//   ForwardAE/ForwardBE            operand selects (00 RF, 10 MEM, 01 WB)
//   StallF/StallD/StallE/FlushE,
//   BubbleM                        pipeline control (combinational)
//   McDoneE                        multi-cycle result valid pulse
//   BusyE                          multi-cycle op in progress
// Optional macro HAZARD_PERF_CNT_EN adds StallCycles[31:0] and McOps[15:0]
// saturating performance counters.
module ex_hazard_ctrl #(
   parameter int unsigned MC_LATENCY = 4,
   parameter int unsigned CNT_W      = 4
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [4:0] RsAddrD,
   input  logic [4:0] RtAddrD,
   input  logic       UseRtD,
   input  logic [4:0] RsAddrE,
   input  logic [4:0] RtAddrE,
   input  logic [4:0] WriteRegE,
   input  logic       RegWriteE,
   input  logic       MemToRegE,
   input  logic       MultiCycleE,
   input  logic       FlushReqE,
   input  logic [4:0] WriteRegM,
   input  logic       RegWriteM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       FlushE,
   output logic       BubbleM,
   output logic       McDoneE,
   output logic       BusyE
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] StallCycles,
   output logic [15:0] McOps
`endif
);

   localparam int unsigned REG_W  = 5;
   localparam int unsigned STC_W  = 32;
   localparam int unsigned MCO_W  = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               lu_c;
   logic               mcs_c;
   logic               done_c;

   // Forward select for one source register: MEM beats WB, r0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
      logic [1:0] sel;
      sel = 2'b00;
      if (RegWriteM && (WriteRegM != '0) && (WriteRegM == src)) begin
         sel = 2'b10;
      end else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == src)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Forwarding stays live during reset.
   always_comb begin
      ForwardAE = fwd_sel(RsAddrE);
      ForwardBE = fwd_sel(RtAddrE);
   end

   // Load in EX feeding an operand of the instruction in decode.
   always_comb begin
      lu_c = MemToRegE && RegWriteE && (WriteRegE != '0) &&
             ((WriteRegE == RsAddrD) || (UseRtD && (WriteRegE == RtAddrD)));
   end

   // Multi-cycle sequencer: next state, counter and stall request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcs_c   = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (MultiCycleE && !FlushReqE) begin
               mcs_c   = 1'b1;
               state_d = BUSY;
               cnt_d   = CNT_W'(MC_LATENCY - 2);
            end
         end
         BUSY: begin
            if (FlushReqE) begin
               // Abort: release stalls now, no completion pulse.
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               done_c  = 1'b1;
               state_d = IDLE;
            end else begin
               mcs_c   = 1'b1;
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Control outputs; held low while reset is asserted. The multi-cycle
   // stall wins over load-use: decode is simply held and re-checked later.
   always_comb begin
      StallF  = RSTn && (lu_c || mcs_c);
      StallD  = RSTn && (lu_c || mcs_c);
      StallE  = RSTn && mcs_c;
      FlushE  = RSTn && lu_c && !mcs_c;
      BubbleM = RSTn && mcs_c;
      McDoneE = RSTn && done_c;
      BusyE   = RSTn && (state_q == BUSY);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [STC_W-1:0] stall_cycles_q;
   logic [MCO_W-1:0] mc_ops_q;

   // Saturating event counters.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         stall_cycles_q <= '0;
         mc_ops_q       <= '0;
      end else begin
         if (StallF && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + STC_W'(1);
         end
         if (McDoneE && (mc_ops_q != '1)) begin
            mc_ops_q <= mc_ops_q + MCO_W'(1);
         end
      end
   end

   assign StallCycles = stall_cycles_q;
   assign McOps       = mc_ops_q;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed self-checking bench for ex_hazard_ctrl
// (MC_LATENCY = 4). Inputs change 1 time unit after the rising edge and
// outputs are checked 1 unit later, mid-cycle.
module tb_ex_hazard_ctrl;

   logic       CLK;
   logic       RSTn;
   logic [4:0] RsAddrD, RtAddrD, RsAddrE, RtAddrE, WriteRegE, WriteRegM, WriteRegW;
   logic       UseRtD, RegWriteE, MemToRegE, MultiCycleE, FlushReqE;
   logic       RegWriteM, RegWriteW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, FlushE, BubbleM, McDoneE, BusyE;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] StallCycles;
   logic [15:0] McOps;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ex_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(4)) dut (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .RsAddrD     (RsAddrD),
      .RtAddrD     (RtAddrD),
      .UseRtD      (UseRtD),
      .RsAddrE     (RsAddrE),
      .RtAddrE     (RtAddrE),
      .WriteRegE   (WriteRegE),
      .RegWriteE   (RegWriteE),
      .MemToRegE   (MemToRegE),
      .MultiCycleE (MultiCycleE),
      .FlushReqE   (FlushReqE),
      .WriteRegM   (WriteRegM),
      .RegWriteM   (RegWriteM),
      .WriteRegW   (WriteRegW),
      .RegWriteW   (RegWriteW),
      .ForwardAE   (ForwardAE),
      .ForwardBE   (ForwardBE),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .FlushE      (FlushE),
      .BubbleM     (BubbleM),
      .McDoneE     (McDoneE),
      .BusyE       (BusyE)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .StallCycles (StallCycles),
      .McOps       (McOps)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      RsAddrD = '0; RtAddrD = '0; UseRtD = 1'b0;
      RsAddrE = '0; RtAddrE = '0; WriteRegE = '0;
      RegWriteE = 1'b0; MemToRegE = 1'b0; MultiCycleE = 1'b0; FlushReqE = 1'b0;
      WriteRegM = '0; RegWriteM = 1'b0; WriteRegW = '0; RegWriteW = 1'b0;
   endtask

   initial begin
      clear_inputs();
      RSTn = 1'b0;

      // Reset: control outputs low even with a start request, forwarding live.
      MultiCycleE = 1'b1;
      RegWriteM = 1'b1; WriteRegM = 5'd5; RsAddrE = 5'd5;
      #3;
      chk("rst_stallf", 32'(StallF), 32'd0);
      chk("rst_stalle", 32'(StallE), 32'd0);
      chk("rst_bubblem", 32'(BubbleM), 32'd0);
      chk("rst_busy", 32'(BusyE), 32'd0);
      chk("rst_done", 32'(McDoneE), 32'd0);
      chk("rst_fwda", 32'(ForwardAE), 32'd2);

      tick();
      clear_inputs();
      RSTn = 1'b1;
      #1;
      chk("idle_stalle", 32'(StallE), 32'd0);
      chk("idle_busy", 32'(BusyE), 32'd0);

      // Forwarding vectors.
      tick();
      RegWriteM = 1'b1; WriteRegM = 5'd5; RegWriteW = 1'b1; WriteRegW = 5'd5; RsAddrE = 5'd5;
      #1; chk("fwd_mem_prio", 32'(ForwardAE), 32'd2);
      WriteRegM = 5'd0; RsAddrE = 5'd0;
      #1; chk("fwd_r0", 32'(ForwardAE), 32'd0);
      RegWriteM = 1'b0; WriteRegM = 5'd5; RtAddrE = 5'd5;
      #1; chk("fwd_wb_b", 32'(ForwardBE), 32'd1);
      RegWriteM = 1'b1; WriteRegM = 5'd3; RtAddrE = 5'd3; RsAddrE = 5'd5;
      #1; chk("fwd_mem_b", 32'(ForwardBE), 32'd2);
      chk("fwd_wb_a", 32'(ForwardAE), 32'd1);
      RegWriteW = 1'b0;
      #1; chk("fwd_none_a", 32'(ForwardAE), 32'd0);
      clear_inputs();

      // Load-use vectors.
      tick();
      MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RtAddrD = 5'd8; UseRtD = 1'b1;
      #1;
      chk("lu_rt_stallf", 32'(StallF), 32'd1);
      chk("lu_rt_stalld", 32'(StallD), 32'd1);
      chk("lu_rt_flushe", 32'(FlushE), 32'd1);
      chk("lu_rt_stalle", 32'(StallE), 32'd0);
      UseRtD = 1'b0;
      #1;
      chk("lu_nort_stallf", 32'(StallF), 32'd0);
      chk("lu_nort_flushe", 32'(FlushE), 32'd0);
      RsAddrD = 5'd8;
      #1; chk("lu_rs_flushe", 32'(FlushE), 32'd1);
      WriteRegE = 5'd0; RsAddrD = 5'd0;
      #1; chk("lu_r0_flushe", 32'(FlushE), 32'd0);
      clear_inputs();

      // Multi-cycle op, MultiCycleE held: two back-to-back ops.
      tick();
      MultiCycleE = 1'b1;
      #1;
      chk("mc_t0_stalle", 32'(StallE), 32'd1);
      chk("mc_t0_bubble", 32'(BubbleM), 32'd1);
      chk("mc_t0_busy", 32'(BusyE), 32'd0);
      chk("mc_t0_done", 32'(McDoneE), 32'd0);
      for (int i = 1; i <= 2; i++) begin
         tick();
         chk("mc_mid_stalle", 32'(StallE), 32'd1);
         chk("mc_mid_stallf", 32'(StallF), 32'd1);
         chk("mc_mid_bubble", 32'(BubbleM), 32'd1);
         chk("mc_mid_busy", 32'(BusyE), 32'd1);
         chk("mc_mid_done", 32'(McDoneE), 32'd0);
      end
      tick();
      chk("mc_t3_done", 32'(McDoneE), 32'd1);
      chk("mc_t3_stalle", 32'(StallE), 32'd0);
      chk("mc_t3_stallf", 32'(StallF), 32'd0);
      chk("mc_t3_bubble", 32'(BubbleM), 32'd0);
      chk("mc_t3_busy", 32'(BusyE), 32'd1);
      tick();
      chk("b2b_t0_stalle", 32'(StallE), 32'd1);
      chk("b2b_t0_busy", 32'(BusyE), 32'd0);
      chk("b2b_t0_done", 32'(McDoneE), 32'd0);
      tick();
      tick();
      chk("b2b_t2_done", 32'(McDoneE), 32'd0);
      tick();
      chk("b2b_t3_done", 32'(McDoneE), 32'd1);
      tick();
      MultiCycleE = 1'b0;
      #1;
      chk("mc_after_busy", 32'(BusyE), 32'd0);
      chk("mc_after_stalle", 32'(StallE), 32'd0);
      chk("mc_after_done", 32'(McDoneE), 32'd0);

      // Abort by FlushReqE one cycle into the op.
      tick();
      MultiCycleE = 1'b1;
      #1; chk("ab_t0_stalle", 32'(StallE), 32'd1);
      tick();
      FlushReqE = 1'b1;
      #1;
      chk("ab_t1_stalle", 32'(StallE), 32'd0);
      chk("ab_t1_stallf", 32'(StallF), 32'd0);
      chk("ab_t1_bubble", 32'(BubbleM), 32'd0);
      chk("ab_t1_done", 32'(McDoneE), 32'd0);
      chk("ab_t1_busy", 32'(BusyE), 32'd1);
      tick();
      FlushReqE = 1'b0; MultiCycleE = 1'b0;
      #1;
      chk("ab_t2_busy", 32'(BusyE), 32'd0);
      chk("ab_t2_done", 32'(McDoneE), 32'd0);
      tick();
      chk("ab_t3_done", 32'(McDoneE), 32'd0);

      // FlushReqE suppresses a start in IDLE.
      MultiCycleE = 1'b1; FlushReqE = 1'b1;
      #1; chk("sup_stalle", 32'(StallE), 32'd0);
      tick();
      chk("sup_busy", 32'(BusyE), 32'd0);
      MultiCycleE = 1'b0; FlushReqE = 1'b0;

      // Load-use held during a multi-cycle op: stall wins, flush after release.
      tick();
      MultiCycleE = 1'b1;
      MemToRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd8; RsAddrD = 5'd8;
      #1;
      chk("lub_t0_flushe", 32'(FlushE), 32'd0);
      chk("lub_t0_stalle", 32'(StallE), 32'd1);
      chk("lub_t0_stallf", 32'(StallF), 32'd1);
      tick();
      chk("lub_t1_flushe", 32'(FlushE), 32'd0);
      chk("lub_t1_stalle", 32'(StallE), 32'd1);
      tick();
      chk("lub_t2_flushe", 32'(FlushE), 32'd0);
      tick();
      MultiCycleE = 1'b0;
      #1; chk("lub_t3_done", 32'(McDoneE), 32'd1);
      tick();
      chk("lub_t4_flushe", 32'(FlushE), 32'd1);
      chk("lub_t4_stallf", 32'(StallF), 32'd1);
      chk("lub_t4_stalld", 32'(StallD), 32'd1);
      chk("lub_t4_stalle", 32'(StallE), 32'd0);
      chk("lub_t4_busy", 32'(BusyE), 32'd0);
      clear_inputs();

`ifdef HAZARD_PERF_CNT_EN
      #1; chk("perf_mcops", 32'(McOps), 32'd3);
`endif

      // Asynchronous reset during BUSY.
      tick();
      MultiCycleE = 1'b1;
      tick();
      chk("rb_t1_busy", 32'(BusyE), 32'd1);
      RSTn = 1'b0;
      #1;
      chk("rb_busy", 32'(BusyE), 32'd0);
      chk("rb_stalle", 32'(StallE), 32'd0);
      chk("rb_stallf", 32'(StallF), 32'd0);
      chk("rb_bubble", 32'(BubbleM), 32'd0);
      chk("rb_done", 32'(McDoneE), 32'd0);
      tick();
      MultiCycleE = 1'b0;
      RSTn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rb_post_done", 32'(McDoneE), 32'd0);
         chk("rb_post_busy", 32'(BusyE), 32'd0);
      end
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_mcops_rst", 32'(McOps), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
